ad9914_pport_responder: RTL and testbench

//  Synthesizable model of the AD9914 parallel-port target. It responds to the 8/16-bit

---
 rtl/ad9914_pkg.sv | 37 +++
 rtl/ad9914_regfile_dual.sv | 84 ++++++++
 rtl/ad9914_pport_responder.sv | 161 ++++++++++++++++
 tb/tb_ad9914_pport_responder.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ad9914_pkg.sv
// Shared AD9914 definitions: register map, bus-mode encodings, responder FSM states
// and the byte-space range check used by both the responder and its register file.
package ad9914_pkg;

    localparam int AD9914_NUM_REGS = 28;

    localparam logic [4:0] CFR1              = 5'h00;
    localparam logic [4:0] CFR2              = 5'h01;
    localparam logic [4:0] CFR3              = 5'h02;
    localparam logic [4:0] CFR4              = 5'h03;
    localparam logic [4:0] DRG_LOWER_LIMIT   = 5'h04;
    localparam logic [4:0] DRG_UPPER_LIMIT   = 5'h05;
    localparam logic [4:0] DRG_RISE_STEP     = 5'h06;
    localparam logic [4:0] DRG_FALL_STEP     = 5'h07;
    localparam logic [4:0] DRG_RATE          = 5'h08;
    localparam logic [4:0] PROFILE0_FTW      = 5'h0B;
    localparam logic [4:0] PROFILE0_POW_AMP  = 5'h0C;

    localparam logic BUS_MODE_8BIT  = 1'b0;
    localparam logic BUS_MODE_16BIT = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WR_ACT  = 2'd1,
        ST_RD_WAIT = 2'd2,
        ST_RD_DRV  = 2'd3
    } pport_state_e;

    // A halfword access is in range only if its upper byte (2h+1) is.
    function automatic logic addr_out_of_range(input logic [7:0] addr, input logic pwd,
                                               input int num_bytes);
        int last_byte;
        last_byte = (pwd == BUS_MODE_16BIT) ? int'({addr[7:1], 1'b1}) : int'(addr);
        return last_byte >= num_bytes;
    endfunction

endpackage

// File: rtl/ad9914_regfile_dual.sv
// Byte-writable buffer register file with an active shadow copy loaded on io_update,
// plus a bus read port from the buffer and a 32-bit configuration read port from the shadow.
module ad9914_regfile_dual
    import ad9914_pkg::*;
#(
    parameter int NUM_REGS = AD9914_NUM_REGS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_i,
    input  logic        wr_pwd_i,
    input  logic [7:0]  wr_addr_i,
    input  logic [15:0] wr_data_i,
    input  logic        update_i,
    input  logic        rd_pwd_i,
    input  logic [7:0]  rd_addr_i,
    output logic [15:0] rd_data_o,
    input  logic [4:0]  cfg_sel_i,
    output logic [31:0] cfg_word_o
);
    localparam int NUM_BYTES = NUM_REGS * 4;
    localparam int AW        = $clog2(NUM_BYTES);

    logic [7:0] buf_q [NUM_BYTES];
    logic [7:0] buf_d [NUM_BYTES];
    logic [7:0] act_q [NUM_BYTES];

    logic [AW-1:0] wr_lo, wr_hi, wr_b, rd_lo, rd_hi, rd_b, cfg_base;

    assign wr_lo    = AW'({wr_addr_i[7:1], 1'b0});
    assign wr_hi    = AW'({wr_addr_i[7:1], 1'b1});
    assign wr_b     = AW'(wr_addr_i);
    assign rd_lo    = AW'({rd_addr_i[7:1], 1'b0});
    assign rd_hi    = AW'({rd_addr_i[7:1], 1'b1});
    assign rd_b     = AW'(rd_addr_i);
    assign cfg_base = AW'({cfg_sel_i, 2'b00});

    // buf_d feeds the shadow too, so an update coinciding with a write sees the new bytes.
    always_comb begin
        buf_d = buf_q;
        if (we_i && !addr_out_of_range(wr_addr_i, wr_pwd_i, NUM_BYTES)) begin
            if (wr_pwd_i == BUS_MODE_16BIT) begin
                buf_d[wr_lo] = wr_data_i[7:0];
                buf_d[wr_hi] = wr_data_i[15:8];
            end else begin
                buf_d[wr_b] = wr_data_i[7:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_BYTES; i++) begin
                buf_q[i] <= 8'h00;
                act_q[i] <= 8'h00;
            end
        end else begin
            buf_q <= buf_d;
            if (update_i) begin
                act_q <= buf_d;
            end
        end
    end

    always_comb begin
        rd_data_o = 16'h0000;
        if (!addr_out_of_range(rd_addr_i, rd_pwd_i, NUM_BYTES)) begin
            if (rd_pwd_i == BUS_MODE_16BIT) begin
                rd_data_o = {buf_q[rd_hi], buf_q[rd_lo]};
            end else begin
                rd_data_o = {8'h00, buf_q[rd_b]};
            end
        end
    end

    always_comb begin
        cfg_word_o = 32'h0000_0000;
        if (int'(cfg_sel_i) < NUM_REGS) begin
            cfg_word_o = {act_q[cfg_base + AW'(3)], act_q[cfg_base + AW'(2)],
                          act_q[cfg_base + AW'(1)], act_q[cfg_base]};
        end
    end

endmodule

// File: rtl/ad9914_pport_responder.sv
// AD9914 parallel-port target: registered input stage, write/read strobe FSM,
// saturating transaction counters and error pulses around a dual register file.
module ad9914_pport_responder
    import ad9914_pkg::*;
#(
    parameter int NUM_REGS = AD9914_NUM_REGS,
    parameter int READ_LAT = 2,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             p_pwd,
    input  logic             p_wr,
    input  logic             p_rd,
    input  logic [7:0]       p_addr,
    input  logic [15:0]      p_wdata,
    output logic [15:0]      p_rdata,
    output logic             data_oe,
    input  logic             io_update,
    input  logic             err_inject,
    input  logic [4:0]       cfg_sel,
    output logic [31:0]      cfg_word,
    output logic [CNT_W-1:0] wr_cnt,
    output logic [CNT_W-1:0] rd_cnt,
    output logic             addr_err,
    output logic             proto_err,
    output logic [1:0]       dbg_state
);
    localparam int NUM_BYTES = NUM_REGS * 4;

    logic        pwd_q, wr_q, wr_qq, rd_q, rd_qq, upd_q, upd_qq;
    logic        prime_q, wr_arm_q, rd_arm_q;
    logic [7:0]  addr_q;
    logic [15:0] wdata_q;

    // A strobe only arms after a genuine high sample, so one held low through reset is ignored.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pwd_q    <= 1'b0;
            wr_q     <= 1'b1;
            wr_qq    <= 1'b1;
            rd_q     <= 1'b1;
            rd_qq    <= 1'b1;
            upd_q    <= 1'b0;
            upd_qq   <= 1'b0;
            addr_q   <= 8'h00;
            wdata_q  <= 16'h0000;
            prime_q  <= 1'b0;
            wr_arm_q <= 1'b0;
            rd_arm_q <= 1'b0;
        end else begin
            pwd_q    <= p_pwd;
            wr_q     <= p_wr;
            wr_qq    <= wr_q;
            rd_q     <= p_rd;
            rd_qq    <= rd_q;
            upd_q    <= io_update;
            upd_qq   <= upd_q;
            addr_q   <= p_addr;
            wdata_q  <= p_wdata;
            prime_q  <= 1'b1;
            wr_arm_q <= wr_arm_q | (prime_q & wr_q);
            rd_arm_q <= rd_arm_q | (prime_q & rd_q);
        end
    end

    logic wr_fall, wr_rise, rd_fall, rd_rise, upd_rise;

    assign wr_fall  = wr_arm_q & wr_qq & ~wr_q;
    assign wr_rise  = ~wr_qq & wr_q;
    assign rd_fall  = rd_arm_q & rd_qq & ~rd_q;
    assign rd_rise  = ~rd_qq & rd_q;
    assign upd_rise = upd_q & ~upd_qq;

    pport_state_e state_q;
    logic [7:0]   lat_cnt_q;
    logic         rd_oor_q;
    logic         wr_commit, acc_oor, lat_done;
    logic [15:0]  rf_rd_data, rd_word;

    assign wr_commit = (state_q == ST_WR_ACT) && wr_rise;
    assign acc_oor   = addr_out_of_range(addr_q, pwd_q, NUM_BYTES);
    assign rd_word   = rf_rd_data ^ {15'd0, err_inject};
    assign lat_done  = (int'(lat_cnt_q) + 2 >= READ_LAT);
    assign dbg_state = 2'(state_q);

    ad9914_regfile_dual #(
        .NUM_REGS(NUM_REGS)
    ) u_regfile (
        .clk        (clk),
        .rst        (rst),
        .we_i       (wr_commit),
        .wr_pwd_i   (pwd_q),
        .wr_addr_i  (addr_q),
        .wr_data_i  (wdata_q),
        .update_i   (upd_rise),
        .rd_pwd_i   (pwd_q),
        .rd_addr_i  (addr_q),
        .rd_data_o  (rf_rd_data),
        .cfg_sel_i  (cfg_sel),
        .cfg_word_o (cfg_word)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            lat_cnt_q <= 8'd0;
            rd_oor_q  <= 1'b0;
            p_rdata   <= 16'h0000;
            data_oe   <= 1'b0;
            wr_cnt    <= '0;
            rd_cnt    <= '0;
            addr_err  <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            addr_err  <= 1'b0;
            proto_err <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if ((wr_fall || rd_fall) && !wr_q && !rd_q) begin
                        proto_err <= 1'b1;
                    end else if (wr_fall) begin
                        state_q <= ST_WR_ACT;
                    end else if (rd_fall) begin
                        state_q   <= ST_RD_WAIT;
                        lat_cnt_q <= 8'd0;
                    end
                end
                ST_WR_ACT: begin
                    if (wr_rise) begin
                        state_q  <= ST_IDLE;
                        addr_err <= acc_oor;
                        if (wr_cnt != '1) wr_cnt <= wr_cnt + CNT_W'(1);
                    end
                end
                ST_RD_WAIT: begin
                    if (rd_rise) begin
                        state_q <= ST_IDLE;
                    end else if (lat_done) begin
                        p_rdata  <= rd_word;
                        rd_oor_q <= acc_oor;
                        data_oe  <= 1'b1;
                        state_q  <= ST_RD_DRV;
                    end else begin
                        lat_cnt_q <= lat_cnt_q + 8'd1;
                    end
                end
                ST_RD_DRV: begin
                    if (rd_rise) begin
                        data_oe  <= 1'b0;
                        addr_err <= rd_oor_q;
                        state_q  <= ST_IDLE;
                        if (rd_cnt != '1) rd_cnt <= rd_cnt + CNT_W'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ad9914_pport_responder.sv
// Bench for the AD9914 parallel-port responder: emulates the bus writer/reader and
// compares against a byte-array model of the buffer and active register files.
`timescale 1ns/1ps
module tb_ad9914_pport_responder;
    import ad9914_pkg::*;

    localparam int NREG  = 28;
    localparam int NB    = NREG * 4;
    localparam int CNT_W = 4;

    logic             clk, rst, p_pwd, p_wr, p_rd, io_update, err_inject;
    logic [7:0]       p_addr;
    logic [15:0]      p_wdata, p_rdata;
    logic             data_oe, addr_err, proto_err;
    logic [4:0]       cfg_sel;
    logic [31:0]      cfg_word;
    logic [CNT_W-1:0] wr_cnt, rd_cnt;
    logic [1:0]       dbg_state;

    int errors = 0;
    int checks = 0;
    int addr_err_seen = 0;
    int proto_err_seen = 0;

    logic [7:0] m_buf [NB];
    logic [7:0] m_act [NB];
    int m_wr = 0, m_rd = 0, m_aerr = 0;

    ad9914_pport_responder #(.NUM_REGS(NREG), .READ_LAT(2), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .p_pwd(p_pwd), .p_wr(p_wr), .p_rd(p_rd), .p_addr(p_addr),
        .p_wdata(p_wdata), .p_rdata(p_rdata), .data_oe(data_oe), .io_update(io_update),
        .err_inject(err_inject), .cfg_sel(cfg_sel), .cfg_word(cfg_word), .wr_cnt(wr_cnt),
        .rd_cnt(rd_cnt), .addr_err(addr_err), .proto_err(proto_err), .dbg_state(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    always @(negedge clk) begin
        if (addr_err === 1'b1) addr_err_seen++;
        if (proto_err === 1'b1) proto_err_seen++;
    end

    // behavioural model
    function automatic bit m_oor(bit pwd, logic [7:0] a);
        int last_byte;
        last_byte = pwd ? (int'(a) / 2) * 2 + 1 : int'(a);
        return last_byte >= NB;
    endfunction

    function automatic logic [15:0] m_read(bit pwd, logic [7:0] a, bit inj);
        logic [15:0] v;
        int h;
        h = int'(a) / 2;
        if (m_oor(pwd, a)) v = 16'h0000;
        else if (pwd) v = {m_buf[2*h+1], m_buf[2*h]};
        else v = {8'h00, m_buf[int'(a)]};
        return v ^ {15'd0, inj};
    endfunction

    function automatic logic [31:0] m_cfg(int sel);
        if (sel >= NREG) return 32'h0;
        return {m_act[4*sel+3], m_act[4*sel+2], m_act[4*sel+1], m_act[4*sel]};
    endfunction

    function automatic logic [CNT_W-1:0] m_sat(int n);
        int lim;
        lim = (1 << CNT_W) - 1;
        return (n >= lim) ? CNT_W'(lim) : CNT_W'(n);
    endfunction

    task automatic m_clear();
        for (int i = 0; i < NB; i++) begin
            m_buf[i] = 8'h00;
            m_act[i] = 8'h00;
        end
        m_wr = 0;
        m_rd = 0;
    endtask

    task automatic m_update();
        for (int i = 0; i < NB; i++) m_act[i] = m_buf[i];
    endtask

    // driver tasks
    task automatic bus_write(input bit pwd, input logic [7:0] a, input logic [15:0] d,
                             input bit upd);
        int h;
        @(negedge clk);
        p_pwd = pwd; p_addr = a; p_wdata = d; p_wr = 1'b0;
        repeat (3) @(negedge clk);
        p_wr = 1'b1;
        if (upd) io_update = 1'b1;
        @(negedge clk);
        io_update = 1'b0;
        repeat (3) @(negedge clk);
        h = int'(a) / 2;
        if (m_oor(pwd, a)) m_aerr++;
        else if (pwd) begin
            m_buf[2*h] = d[7:0];
            m_buf[2*h+1] = d[15:8];
        end else m_buf[int'(a)] = d[7:0];
        if (upd) m_update();
        m_wr++;
    endtask

    task automatic bus_read(input bit pwd, input logic [7:0] a, output logic [15:0] data);
        bit ok;
        ok = 1'b0;
        @(negedge clk);
        p_pwd = pwd; p_addr = a; p_rd = 1'b0;
        for (int i = 0; i < 12 && !ok; i++) begin
            @(negedge clk);
            if (data_oe === 1'b1) ok = 1'b1;
        end
        data = p_rdata;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL read_timeout addr=%h: data_oe never rose", a);
        end
        @(negedge clk);
        p_rd = 1'b1;
        repeat (3) @(negedge clk);
        if (ok) begin
            m_rd++;
            if (m_oor(pwd, a)) m_aerr++;
        end
    endtask

    task automatic pulse_update();
        @(negedge clk);
        io_update = 1'b1;
        @(negedge clk);
        io_update = 1'b0;
        repeat (3) @(negedge clk);
        m_update();
    endtask

    // scenarios
    task automatic test_reset();
        checks++; if (p_rdata !== 16'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", p_rdata); end
        checks++; if (data_oe !== 1'b0) begin errors++; $display("FAIL reset_oe got=%b exp=0", data_oe); end
        checks++; if (wr_cnt !== '0 || rd_cnt !== '0) begin errors++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", wr_cnt, rd_cnt); end
        checks++; if (addr_err !== 1'b0 || proto_err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b%b exp=00", addr_err, proto_err); end
        checks++; if (dbg_state !== 2'(ST_IDLE)) begin errors++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, ST_IDLE); end
        cfg_sel = 5'd0; #1;
        checks++; if (cfg_word !== 32'h0) begin errors++; $display("FAIL reset_cfg got=%h exp=0", cfg_word); end
    endtask

    task automatic test_halfword();
        logic [15:0] d;
        bus_write(1'b1, 8'h0D, 16'hA5C3, 1'b0);
        bus_read(1'b0, 8'h0C, d);
        checks++; if (d !== 16'h00C3) begin errors++; $display("FAIL hw_byte0C got=%h exp=00c3", d); end
        bus_read(1'b0, 8'h0D, d);
        checks++; if (d !== 16'h00A5) begin errors++; $display("FAIL hw_byte0D got=%h exp=00a5", d); end
        bus_read(1'b1, 8'h0D, d);
        checks++; if (d !== 16'hA5C3) begin errors++; $display("FAIL hw_read got=%h exp=a5c3", d); end
        @(negedge clk); cfg_sel = 5'd3; #1;
        checks++; if (cfg_word !== 32'h0) begin errors++; $display("FAIL hw_cfg_preupd got=%h exp=0", cfg_word); end
        pulse_update();
        checks++; if (cfg_word !== 32'h0000A5C3) begin errors++; $display("FAIL hw_cfg_upd got=%h exp=0000a5c3", cfg_word); end
    endtask

    task automatic test_write_verify();
        logic [15:0] d;
        err_inject = 1'b0;
        bus_write(1'b1, 8'h0C, 16'h5678, 1'b0);
        bus_write(1'b1, 8'h0E, 16'h1234, 1'b0);
        bus_read(1'b1, 8'h0C, d);
        checks++; if (d !== 16'h5678) begin errors++; $display("FAIL wv_lo got=%h exp=5678", d); end
        bus_read(1'b1, 8'h0E, d);
        checks++; if (d !== 16'h1234) begin errors++; $display("FAIL wv_hi got=%h exp=1234", d); end
        checks++; if (wr_cnt !== m_sat(m_wr) || rd_cnt !== m_sat(m_rd)) begin
            errors++; $display("FAIL wv_cnt got=%0d/%0d exp=%0d/%0d", wr_cnt, rd_cnt, m_sat(m_wr), m_sat(m_rd)); end
        err_inject = 1'b1;
        bus_read(1'b1, 8'h0C, d);
        checks++; if (d !== 16'h5679) begin errors++; $display("FAIL inj_lo got=%h exp=5679", d); end
        bus_read(1'b1, 8'h0E, d);
        checks++; if (d !== 16'h1235) begin errors++; $display("FAIL inj_hi got=%h exp=1235", d); end
        err_inject = 1'b0;
    endtask

    task automatic test_out_of_range();
        logic [15:0] d;
        int a0;
        a0 = addr_err_seen;
        bus_write(1'b0, 8'h6F, 16'h007E, 1'b0);
        checks++; if (addr_err_seen !== a0) begin errors++; $display("FAIL oor_inrange_pulse got=%0d exp=%0d", addr_err_seen, a0); end
        bus_write(1'b0, 8'h70, 16'h007E, 1'b0);
        checks++; if (addr_err_seen !== a0 + 1) begin errors++; $display("FAIL oor_wr_pulse got=%0d exp=%0d", addr_err_seen, a0 + 1); end
        bus_read(1'b0, 8'h6F, d);
        checks++; if (d !== 16'h007E) begin errors++; $display("FAIL oor_6F got=%h exp=007e", d); end
        bus_read(1'b0, 8'h70, d);
        checks++; if (d !== 16'h0000) begin errors++; $display("FAIL oor_70 got=%h exp=0000", d); end
        checks++; if (addr_err_seen !== a0 + 2) begin errors++; $display("FAIL oor_rd_pulse got=%0d exp=%0d", addr_err_seen, a0 + 2); end
        bus_read(1'b1, 8'h6F, d);
        checks++; if (d !== m_read(1'b1, 8'h6F, 1'b0)) begin errors++; $display("FAIL oor_hw_last got=%h exp=%h", d, m_read(1'b1, 8'h6F, 1'b0)); end
    endtask

    task automatic test_update_same_cycle();
        bus_write(1'b1, 8'h00, 16'hBEEF, 1'b1);
        bus_write(1'b1, 8'h02, 16'hCAFE, 1'b1);
        @(negedge clk); cfg_sel = 5'd0; #1;
        checks++; if (cfg_word !== 32'hCAFEBEEF) begin errors++; $display("FAIL upd_same_cycle got=%h exp=cafebeef", cfg_word); end
    endtask

    task automatic test_proto();
        int p0;
        p0 = proto_err_seen;
        @(negedge clk);
        p_wr = 1'b0; p_rd = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (data_oe !== 1'b0) begin errors++; $display("FAIL proto_oe got=%b exp=0", data_oe); end
        p_wr = 1'b1; p_rd = 1'b1;
        repeat (4) @(negedge clk);
        checks++; if (proto_err_seen !== p0 + 1) begin errors++; $display("FAIL proto_pulse got=%0d exp=%0d", proto_err_seen, p0 + 1); end
        checks++; if (wr_cnt !== m_sat(m_wr) || rd_cnt !== m_sat(m_rd)) begin
            errors++; $display("FAIL proto_cnt got=%0d/%0d exp=%0d/%0d", wr_cnt, rd_cnt, m_sat(m_wr), m_sat(m_rd)); end
    endtask

    task automatic test_random();
        logic [15:0] d, e;
        logic [7:0] a;
        bit pw, inj;
        int sel;
        for (int n = 0; n < 60; n++) begin
            pw = 1'($urandom_range(0, 1));
            a  = 8'($urandom_range(0, 127));
            case ($urandom_range(0, 2))
                0: bus_write(pw, a, 16'($urandom), ($urandom_range(0, 3) == 0));
                1: begin
                    inj = 1'($urandom_range(0, 1));
                    err_inject = inj;
                    e = m_read(pw, a, inj);
                    bus_read(pw, a, d);
                    err_inject = 1'b0;
                    checks++; if (d !== e) begin errors++; $display("FAIL rand_read pwd=%0d addr=%h got=%h exp=%h", pw, a, d, e); end
                end
                default: begin
                    sel = $urandom_range(0, 31);
                    @(negedge clk); cfg_sel = 5'(sel); #1;
                    checks++; if (cfg_word !== m_cfg(sel)) begin errors++; $display("FAIL rand_cfg sel=%0d got=%h exp=%h", sel, cfg_word, m_cfg(sel)); end
                end
            endcase
        end
        checks++; if (addr_err_seen !== m_aerr) begin errors++; $display("FAIL rand_addr_err got=%0d exp=%0d", addr_err_seen, m_aerr); end
        checks++; if (wr_cnt !== m_sat(m_wr) || rd_cnt !== m_sat(m_rd)) begin
            errors++; $display("FAIL rand_cnt got=%0d/%0d exp=%0d/%0d", wr_cnt, rd_cnt, m_sat(m_wr), m_sat(m_rd)); end
    endtask

    task automatic test_saturation();
        logic [15:0] d;
        for (int i = 0; i < 17; i++) bus_write(1'b0, 8'h10, 16'(i), 1'b0);
        for (int i = 0; i < 17; i++) bus_read(1'b0, 8'h10, d);
        checks++; if (wr_cnt !== 4'hF) begin errors++; $display("FAIL sat_wr got=%0d exp=15", wr_cnt); end
        checks++; if (rd_cnt !== 4'hF) begin errors++; $display("FAIL sat_rd got=%0d exp=15", rd_cnt); end
        checks++; if (d !== 16'h0010) begin errors++; $display("FAIL sat_last_data got=%h exp=0010", d); end
    endtask

    task automatic test_reset_mid_read();
        logic [15:0] d;
        bit ok;
        ok = 1'b0;
        @(negedge clk);
        p_pwd = 1'b1; p_addr = 8'h00; p_rd = 1'b0;
        for (int i = 0; i < 12 && !ok; i++) begin
            @(negedge clk);
            if (data_oe === 1'b1) ok = 1'b1;
        end
        checks++; if (!ok) begin errors++; $display("FAIL rst_mid_reach_drv: data_oe never rose"); end
        rst = 1'b0;
        #1;
        m_clear();
        checks++; if (data_oe !== 1'b0 || p_rdata !== 16'h0) begin errors++; $display("FAIL rst_mid_oe got=%b/%h exp=0/0000", data_oe, p_rdata); end
        checks++; if (wr_cnt !== '0 || rd_cnt !== '0) begin errors++; $display("FAIL rst_mid_cnt got=%0d/%0d exp=0/0", wr_cnt, rd_cnt); end
        @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        checks++; if (data_oe !== 1'b0 || dbg_state !== 2'(ST_IDLE)) begin
            errors++; $display("FAIL rst_held_rd got=oe%b st%0d exp=oe0 st0", data_oe, dbg_state); end
        p_rd = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (rd_cnt !== '0) begin errors++; $display("FAIL rst_held_rd_cnt got=%0d exp=0", rd_cnt); end
        bus_read(1'b1, 8'h00, d);
        checks++; if (d !== 16'h0000 || rd_cnt !== m_sat(m_rd)) begin
            errors++; $display("FAIL rst_after_read got=%h/%0d exp=0000/%0d", d, rd_cnt, m_sat(m_rd)); end
    endtask

    initial begin
        rst = 1'b0; p_pwd = 1'b0; p_wr = 1'b1; p_rd = 1'b1; p_addr = 8'h00;
        p_wdata = 16'h0; io_update = 1'b0; err_inject = 1'b0; cfg_sel = 5'd0;
        m_clear();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        test_reset();
        test_halfword();
        test_write_verify();
        test_out_of_range();
        test_update_same_cycle();
        test_proto();
        test_random();
        test_saturation();
        test_reset_mid_read();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
